// File: rtl/sqrt_unit.sv
// sqrt_unit: sequential digit-by-digit floor square root of a signed fixed-point radicand
module sqrt_unit #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] radicand,
    output logic [WIDTH-1:0] root,
    output logic             ready,
    output logic             busy,
    output logic             neg_err
);
    localparam int N  = (WIDTH + FRAC) / 2;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state, state_next;
    logic [2*N-1:0] x;
    logic [N+1:0]   rem, rem_sh, t;
    logic [N-1:0]   q, q_next;
    logic [CW-1:0]  cnt;
    logic           accept, neg, ge, last;

    // next state plus the single-iteration remainder/root step
    always_comb begin
        accept     = start && state != CALC;
        neg        = radicand[WIDTH-1];
        rem_sh     = (rem << 2) | (N+2)'(x[2*N-1:2*N-2]);
        t          = {q, 2'b01};
        ge         = rem_sh >= t;
        q_next     = {q[N-2:0], ge};
        last       = cnt == '0;
        state_next = state;
        if (accept)
            state_next = neg ? DONE : CALC;
        else if (state == CALC && last)
            state_next = DONE;
    end

    // state register
    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // datapath and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            x       <= '0;
            rem     <= '0;
            q       <= '0;
            cnt     <= '0;
            root    <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            neg_err <= 1'b0;
        end else if (accept) begin
            x       <= {radicand, {FRAC{1'b0}}};
            rem     <= '0;
            q       <= '0;
            cnt     <= CW'(N - 1);
            ready   <= 1'b0;
            busy    <= !neg;
            neg_err <= neg;
            if (neg)
                root <= '0;
        end else if (state == CALC) begin
            x   <= x << 2;
            rem <= ge ? rem_sh - t : rem_sh;
            q   <= q_next;
            cnt <= cnt - 1'b1;
            if (last) begin
                root  <= WIDTH'(q_next);
                ready <= 1'b1;
                busy  <= 1'b0;
            end
        end else if (state == DONE) begin
            ready <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sqrt_unit.sv
// tb_sqrt_unit: table, random and handshake checks of sqrt_unit against a binary-search reference
module tb_sqrt_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] radicand = '0;
    logic [31:0] root;
    logic        ready, busy, neg_err;
    int          vectors = 0;
    int          miscompares = 0;

    typedef struct {
        logic [31:0] rad;
        logic [31:0] root;
        logic        neg;
    } vec_t;

    vec_t tbl[7];

    sqrt_unit #(.WIDTH(32), .FRAC(16)) dut (
        .clock(clock), .reset(reset), .start(start), .radicand(radicand),
        .root(root), .ready(ready), .busy(busy), .neg_err(neg_err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    function automatic logic [31:0] model(input logic [31:0] r);
        longint unsigned v, lo, hi, mid;
        if (r[31]) return 32'h0;
        v  = {16'h0, r, 16'h0};
        lo = 0;
        hi = 64'd1 << 24;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= v) lo = mid;
            else hi = mid;
        end
        return 32'(lo);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] r, input logic [31:0] exp_root, input logic exp_neg,
                          input string tag, input int inject);
        int lat;
        start = 1'b1;
        radicand = r;
        @(posedge clock); #1;
        start = 1'b0;
        radicand = $urandom;
        check({tag, " ready_clear"}, ready, 0);
        check({tag, " busy_start"}, busy, !exp_neg);
        lat = 0;
        while (!ready && lat < 40) begin
            if (lat == inject) begin
                start = 1'b1;
                radicand = $urandom;
            end
            @(posedge clock); #1;
            start = 1'b0;
            lat++;
        end
        check({tag, " latency"}, lat, exp_neg ? 1 : 24);
        check({tag, " root"}, root, exp_root);
        check({tag, " neg_err"}, neg_err, exp_neg);
        check({tag, " busy_end"}, busy, 0);
    endtask

    initial begin
        logic [31:0] r;
        tbl[0] = '{32'h00040000, 32'h00020000, 1'b0};
        tbl[1] = '{32'h00020000, 32'h00016A09, 1'b0};
        tbl[2] = '{32'h7FFFFFFF, 32'h00B504F3, 1'b0};
        tbl[3] = '{32'h00000000, 32'h00000000, 1'b0};
        tbl[4] = '{32'h00000001, 32'h00000100, 1'b0};
        tbl[5] = '{32'hFFFF0000, 32'h00000000, 1'b1};
        tbl[6] = '{32'h00010000, 32'h00010000, 1'b0};

        repeat (2) @(posedge clock);
        #1;
        check("reset root", root, 0);
        check("reset ready", ready, 0);
        check("reset busy", busy, 0);
        check("reset neg_err", neg_err, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 7; i++)
            run_op(tbl[i].rad, tbl[i].root, tbl[i].neg, $sformatf("table%0d", i), -1);

        for (int i = 0; i < 20; i++) begin
            r = $urandom;
            if (i % 4 == 0) r = r & 32'h0000FFFF;
            run_op(r, model(r), r[31], $sformatf("rand%0d", i), -1);
        end

        for (int i = 0; i < 3; i++) begin
            r = $urandom & 32'h7FFFFFFF;
            run_op(r, model(r), 1'b0, $sformatf("cu%0d", i), 3 + 5 * i);
            repeat (2) @(posedge clock);
            #1;
        end

        start = 1'b1;
        radicand = 32'h00050000;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        check("midcalc busy_before_reset", busy, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        check("midreset root", root, 0);
        check("midreset ready", ready, 0);
        check("midreset busy", busy, 0);
        check("midreset neg_err", neg_err, 0);
        reset = 1'b0;
        run_op(32'h00090000, 32'h00030000, 1'b0, "after_reset", -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
